// File: rtl/tiny_npu_pkg.sv
// Shared types and width helpers for the NPU host loader.
package tiny_npu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_X = 2'd2,
    DONE   = 2'd3
  } load_state_e;

  // Index width for a SIZE-entry dimension; never below one bit.
  function automatic int sel_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Flat address width for a SIZE x SIZE matrix.
  function automatic int addr_width(input int size);
    return (size * size > 1) ? $clog2(size * size) : 1;
  endfunction

endpackage

// File: rtl/npu_stage_regfile.sv
// Host staging register file: one synchronous write port, one combinational read port.
module npu_stage_regfile
  import tiny_npu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NBITS = 8,
  parameter int AW    = sel_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NBITS-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem [DEPTH];

  // NOTE: the staging array is built from flops, not RAM, because a reset must
  // clear every entry; a RAM macro could not be cleared in a single cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: sequential state always uses non-blocking assignment.
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tiny_npu_loader.sv
// Streams staged weights, then inputs, onto the NPU datapath load ports.
module tiny_npu_loader
  import tiny_npu_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int NBITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         wr_is_w,
  input  logic [addr_width(SIZE)-1:0]  wr_addr,
  input  logic [NBITS-1:0]             wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [NBITS-1:0]             w_in,
  output logic                         w_load_val,
  output logic [sel_width(SIZE)-1:0]   w_load_sel,
  input  logic                         w_ready,
  output logic [NBITS-1:0]             x_in,
  output logic                         x_load_val,
  input  logic                         x_ready
);

  localparam int SW = sel_width(SIZE);
  localparam int AW = addr_width(SIZE);
  localparam logic [SW-1:0] LAST   = SW'(SIZE - 1);
  localparam logic [AW-1:0] SIZE_A = AW'(SIZE);

  load_state_e state_q, state_d;
  logic [SW-1:0] r_q, c_q, k_q;
  logic [SW-1:0] r_d, c_d, k_d;

  logic w_xfer, x_xfer;
  logic w_we, x_we;
  logic [SW-1:0] x_waddr;
  logic [AW-1:0] w_raddr;
  logic [NBITS-1:0] w_rd_raw, x_rd_raw, w_rd, x_rd;

  logic             busy_d, done_d, w_val_d, x_val_d;
  logic [SW-1:0]    w_sel_d;
  logic [NBITS-1:0] w_in_d, x_in_d;

  assign w_xfer = w_load_val && w_ready;
  assign x_xfer = x_load_val && x_ready;

  // Host writes are only honoured while idle, so staging is frozen during a stream.
  assign w_we    = wr_en && wr_is_w && (state_q == IDLE);
  assign x_we    = wr_en && !wr_is_w && (state_q == IDLE) && (wr_addr < SIZE_A);
  assign x_waddr = wr_addr[SW-1:0];

  // Read at the next-cycle indices so the registered outputs line up with the state.
  assign w_raddr = AW'(r_d) * SIZE_A + AW'(c_d);

  npu_stage_regfile #(
    .DEPTH (SIZE * SIZE),
    .NBITS (NBITS),
    .AW    (AW)
  ) u_w_stage (
    .clk   (clk),
    .rst   (rst),
    .we    (w_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (w_raddr),
    .rdata (w_rd_raw)
  );

  npu_stage_regfile #(
    .DEPTH (SIZE),
    .NBITS (NBITS),
    .AW    (SW)
  ) u_x_stage (
    .clk   (clk),
    .rst   (rst),
    .we    (x_we),
    .waddr (x_waddr),
    .wdata (wr_data),
    .raddr (k_d),
    .rdata (x_rd_raw)
  );

  // A write landing on the same edge as start must already show in the first word.
  assign w_rd = (w_we && (wr_addr == w_raddr)) ? wr_data : w_rd_raw;
  assign x_rd = (x_we && (x_waddr == k_d))     ? wr_data : x_rd_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end
      end
      LOAD_W: begin
        if (w_xfer) begin
          if (c_q == LAST) begin
            c_d = '0;
            if (r_q == LAST) begin
              r_d     = '0;
              state_d = LOAD_X;
            end else begin
              r_d = r_q + SW'(1);
            end
          end else begin
            c_d = c_q + SW'(1);
          end
        end
      end
      LOAD_X: begin
        if (x_xfer) begin
          if (k_q == LAST) begin
            k_d     = '0;
            state_d = DONE;
          end else begin
            k_d = k_q + SW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on edges.
  always_comb begin
    busy_d  = (state_d == LOAD_W) || (state_d == LOAD_X);
    done_d  = (state_d == DONE);
    w_val_d = (state_d == LOAD_W);
    x_val_d = (state_d == LOAD_X);
    w_sel_d = w_val_d ? r_d  : '0;
    w_in_d  = w_val_d ? w_rd : '0;
    x_in_d  = x_val_d ? x_rd : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      w_load_val <= 1'b0;
      x_load_val <= 1'b0;
      w_load_sel <= '0;
      w_in       <= '0;
      x_in       <= '0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      w_load_val <= w_val_d;
      x_load_val <= x_val_d;
      w_load_sel <= w_sel_d;
      w_in       <= w_in_d;
      x_in       <= x_in_d;
    end
  end

endmodule

// File: doc/tiny_npu_loader.md
Name: tiny_npu_loader

Overview:
Host-side transmitter that feeds the NPU datapath's input load interface. The host writes a SIZE x SIZE weight matrix and a SIZE-element input vector into internal staging registers. On a start pulse the block streams all weights, then all inputs, onto the datapath's x/w load ports. Each stream uses valid/ready backpressure taken from the datapath's FIFO-full status.

Parameters:
SIZE, 4, array dimension; number of weight FIFOs and input vector length
NBITS, 8, data word width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
wr_en  in  1  host staging write strobe
wr_is_w  in  1  1 = write weight staging, 0 = write input staging
wr_addr  in  $clog2(SIZE*SIZE)  weight: row*SIZE+col; input: element index (must be < SIZE)
wr_data  in  NBITS  staging write data
start  in  1  one-cycle request to begin streaming
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last input transfer
w_in  out  NBITS  weight word to datapath
w_load_val  out  1  weight word valid
w_load_sel  out  $clog2(SIZE)  destination weight FIFO index (matrix row)
w_ready  in  1  datapath can accept a weight word this cycle
x_in  out  NBITS  input word to datapath
x_load_val  out  1  input word valid
x_ready  in  1  datapath can accept an input word this cycle

Behaviour:
- Reset (rst=1 at a clk edge), including mid-operation:
  - FSM returns to IDLE.
  - busy, done, w_load_val and x_load_val go to 0.
  - w_in, x_in and w_load_sel go to 0.
  - Counters and all staging registers clear to 0.
- All outputs are registered.
- Staging writes are accepted only in IDLE:
  - wr_en with wr_is_w=1 writes w_stage[wr_addr].
  - wr_en with wr_is_w=0 writes x_stage[wr_addr] only if wr_addr < SIZE; otherwise the write is dropped.
  - wr_en outside IDLE is dropped.
  - A write takes effect at the clock edge it is sampled on.
- FSM states: IDLE, LOAD_W, LOAD_X, DONE.
  - IDLE -> LOAD_W on start=1. Indices r=0, c=0 and k=0 are set. start is ignored in every other state.
  - LOAD_W: w_load_val=1, w_in=w_stage[r*SIZE+c], w_load_sel=r.
    - A transfer occurs when w_load_val && w_ready.
    - On a transfer c increments; when c wraps SIZE-1 -> 0, r increments.
    - The transfer at r=c=SIZE-1 moves the FSM to LOAD_X.
    - If w_ready=0, data and sel hold stable and valid stays high.
  - LOAD_X: x_load_val=1, x_in=x_stage[k].
    - A transfer occurs when x_load_val && x_ready; k then increments.
    - The transfer at k=SIZE-1 moves the FSM to DONE.
    - If x_ready=0, data holds stable.
  - DONE: done=1 for exactly one cycle, busy=0 from this cycle, next state IDLE.
- w_load_val and x_load_val are never high in the same cycle.
- Ready inputs are ignored whenever the corresponding valid is low.
- Latency:
  - start sampled at edge t -> busy=1, w_load_val=1 and w_in=w[0][0] visible after edge t.
  - With ready tied high: SIZE*SIZE weight cycles, then SIZE input cycles, then the done cycle.
  - Total for SIZE=4: 4*4 + 4 + 1 = 21 cycles.
- A start coincident with wr_en in IDLE: the write lands on the same edge, and the stream reflects the written value.
- Staging contents persist after done; a new start re-sends the same data.

Decomposition:
- Shared package tiny_npu_pkg holds:
  - the loader state enum (IDLE, LOAD_W, LOAD_X, DONE);
  - the width helpers for $clog2(SIZE) and $clog2(SIZE*SIZE).
- One natural sub-module: npu_stage_regfile, parameterised by depth and NBITS.
  - One synchronous write port with a reset that clears all entries.
  - One combinational read port.
  - Instantiated twice: weights at depth SIZE*SIZE, inputs at depth SIZE.
- FSM and counters live in the top module.

Test Plan:
- Full stream, no stall:
  - Stimulus: write w[r][c] = 16*r + c and x[k] = 0xA0 + k (SIZE=4), w_ready = x_ready = 1, pulse start.
  - Required: w_in = 0x00, 0x01, ..., 0x33 with w_load_sel = 0,0,0,0,1,... across 16 cycles; then x_in = A0..A3; done on cycle 21; busy high cycles 1-20.
- Backpressure:
  - Stimulus: hold w_ready=0 for 3 cycles at w[1][2]; hold x_ready=0 for 2 cycles at x[3].
  - Required: w_in=0x12 with sel=1 and val=1 stays stable while stalled; x_in=0xA3 stays stable; no word is skipped or duplicated; done arrives 5 cycles later than in the no-stall case.
- Ignored controls:
  - Stimulus: pulse start during LOAD_W; write wr_is_w=1 addr 0 data 0xFF during LOAD_X; write x at addr SIZE while IDLE.
  - Required: no restart; w_stage[0] unchanged on the next run; x_stage unchanged.
- Reset mid-stream:
  - Stimulus: assert rst in LOAD_W at r=2.
  - Required: next cycle all valids, busy and done are 0 and all data outputs are 0; a new start streams all-zero data, because staging is cleared.
- Re-run:
  - Stimulus: pulse start again after done, with no new writes.
  - Required: an identical stream to the first scenario.
- Start with write:
  - Stimulus: in IDLE, wr_en to w addr 0 with data 0x5A in the same cycle as start.
  - Required: first w_in = 0x5A.
